// File: rtl/arbiter_types.sv
// Shared arbiter definitions, reused by the single-word and cache-line arbiters.
// Ports: none (package).
package arbiter_types;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

  // Width of a counter that must hold 0..limit; never narrower than 1 bit.
  function automatic int starve_cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/rv32i_types.sv
// Core-wide RV32I type definitions shared across the CPU memory path.
// Ports: none (package).
package rv32i_types;

  typedef logic [31:0] rv32i_word;

endpackage

// File: rtl/mem_arbiter.sv
// Purpose : shares one word-wide memory port between fetch (read-only) and data (read/write).
// Latency : request seen in IDLE at cycle N drives mem_* from cycle N+1; resp is same-cycle combinational.
// Backpres: requesters hold their request until resp; one IDLE bubble separates transactions.
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   i_read/i_address -> i_rdata/i_resp     fetch requester side
//   d_read/d_write/d_byte_enable/d_address/d_wdata -> d_rdata/d_resp   data requester side
//   mem_read/mem_write/mem_byte_enable/mem_address/mem_wdata <- mem_rdata/mem_resp   memory side
module mem_arbiter
  import rv32i_types::*;
  import arbiter_types::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_read,
  input  logic [31:0] i_address,
  output logic [31:0] i_rdata,
  output logic        i_resp,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [3:0]  d_byte_enable,
  input  logic [31:0] d_address,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_resp,
  output logic        mem_read,
  output logic        mem_write,
  output logic [3:0]  mem_byte_enable,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp
);

  localparam int CW = starve_cnt_width(STARVE_LIMIT);
  localparam logic [CW-1:0] LIMIT_C = CW'(STARVE_LIMIT);

  arb_state_t  state_q, state_d;
  logic [CW-1:0] starve_q, starve_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic [3:0]  be_q, be_d;
  rv32i_word   addr_q, addr_d;
  rv32i_word   wdata_q, wdata_d;

  logic d_req;
  logic fetch_starved;
  logic busy;

  assign d_req = d_read | d_write;
  // A waiting fetch that has already watched STARVE_LIMIT data grants wins the
  // next decision. With STARVE_LIMIT=0 this makes fetch strictly first.
  assign fetch_starved = i_read && (starve_q == LIMIT_C);

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    be_d     = be_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    case (state_q)
      IDLE: begin
        if (d_req && !fetch_starved) begin
          state_d = SERVE_D;
          // Read+write together is illegal; the write wins so the strobes stay exclusive.
          rd_d    = ~d_write;
          wr_d    = d_write;
          be_d    = d_byte_enable;
          addr_d  = d_address;
          wdata_d = d_wdata;
          if (i_read && (starve_q != LIMIT_C)) begin
            starve_d = starve_q + CW'(1);
          end
        end else if (i_read) begin
          state_d  = SERVE_I;
          rd_d     = 1'b1;
          wr_d     = 1'b0;
          be_d     = 4'hF;
          addr_d   = i_address;
          wdata_d  = '0;
          starve_d = '0;
        end
      end
      SERVE_I, SERVE_D: begin
        // Always drop back to IDLE: the bubble lets the requester retire its
        // request before the next decision.
        if (mem_resp) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      starve_q <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      be_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      be_q     <= be_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  // Memory side comes only from the latched request, gated off in IDLE, so it
  // cannot follow a requester that changes its mind mid-transaction.
  assign busy            = (state_q != IDLE);
  assign mem_read        = busy & rd_q;
  assign mem_write       = busy & wr_q;
  assign mem_byte_enable = busy ? be_q : 4'h0;
  assign mem_address     = busy ? addr_q : '0;
  assign mem_wdata       = busy ? wdata_q : '0;

  // A resp arriving in IDLE (e.g. left over from before a reset) routes nowhere.
  assign i_resp  = (state_q == SERVE_I) & mem_resp;
  assign d_resp  = (state_q == SERVE_D) & mem_resp;
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

  always_ff @(posedge clk) begin
    if (!rst) begin
      a_no_read_write: assert (!(state_q == IDLE && d_read && d_write))
        else $warning("mem_arbiter: d_read and d_write both set at grant, served as write");
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  import arbiter_types::*;

  localparam int LIM = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_read;
  logic [31:0] i_address;
  logic [31:0] i_rdata;
  logic        i_resp;
  logic        d_read;
  logic        d_write;
  logic [3:0]  d_byte_enable;
  logic [31:0] d_address;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_resp;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_resp;

  mem_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_byte_enable(d_byte_enable),
    .d_address(d_address), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Behavioural memory: sparse word store plus a log of completed transactions.
  typedef struct { bit wr; logic [31:0] addr; } log_t;
  logic [31:0] mem_model [logic [31:0]];
  log_t        mem_log [$];
  int          act_cnt = 0;
  int          cur_lat = 1;
  int          fixed_lat = 0;
  bit          mem_manual = 1'b0;

  int both_resp_cnt = 0;
  int rw_cnt = 0;

  always @(negedge clk) begin
    if (i_resp && d_resp) both_resp_cnt <= both_resp_cnt + 1;
    if (mem_read && mem_write) rw_cnt <= rw_cnt + 1;
  end

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return a ^ 32'h5A5A_0F0F;
  endfunction

  task automatic memory_step();
    logic [31:0] w;
    if (mem_manual) return;
    if (mem_resp) begin
      mem_resp = 1'b0;
      act_cnt  = 0;
    end else if (mem_read || mem_write) begin
      act_cnt++;
      if (act_cnt == 1) cur_lat = (fixed_lat > 0) ? fixed_lat : $urandom_range(1, 4);
      if (act_cnt >= cur_lat) begin
        mem_resp = 1'b1;
        mem_log.push_back('{mem_write, mem_address});
        if (mem_write) begin
          w = rd_word(mem_address);
          for (int b = 0; b < 4; b++)
            if (mem_byte_enable[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
          mem_model[mem_address] = w;
          mem_rdata = $urandom;
        end else begin
          mem_rdata = rd_word(mem_address);
        end
      end
    end else begin
      act_cnt = 0;
    end
  endtask

  // Edge, let the memory react, settle; caller then samples and drives.
  task automatic tick();
    @(posedge clk);
    #1;
    memory_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_read = 0; i_address = 0;
    d_read = 0; d_write = 0; d_byte_enable = 0; d_address = 0; d_wdata = 0;
    mem_manual = 0; mem_resp = 0; mem_rdata = 0; act_cnt = 0; fixed_lat = 0;
    mem_log.delete();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({mem_read, mem_write} !== 2'b00) begin
      bad++; $display("FAIL reset_strobes got=%b want=00", {mem_read, mem_write});
    end
    total++;
    if ({mem_byte_enable, mem_address, mem_wdata} !== 68'h0) begin
      bad++; $display("FAIL reset_mem_bus got be=%h addr=%h wdata=%h want all 0",
                      mem_byte_enable, mem_address, mem_wdata);
    end
    total++;
    if ({i_resp, d_resp} !== 2'b00) begin
      bad++; $display("FAIL reset_resp got=%b want=00", {i_resp, d_resp});
    end
    total++;
    if (dut.state_q !== IDLE || dut.starve_q !== 2'd0) begin
      bad++; $display("FAIL reset_state got state=%0d starve=%0d want 0/0", dut.state_q, dut.starve_q);
    end
  endtask

  task automatic test_single_fetch();
    int resp_n = 0;
    bit d_seen = 0;
    bit addr_ok = 1;
    do_reset();
    mem_model[32'h60] = 32'h0000_0013;
    fixed_lat = 3;
    i_read = 1; i_address = 32'h60;
    tick();
    total++;
    if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_address !== 32'h60 || mem_byte_enable !== 4'hF) begin
      bad++; $display("FAIL fetch_strobe got rd=%b wr=%b addr=%h be=%h want 1/0/60/f",
                      mem_read, mem_write, mem_address, mem_byte_enable);
    end
    for (int c = 0; c < 12; c++) begin
      if (d_resp) d_seen = 1;
      if (mem_read && mem_address !== 32'h60) addr_ok = 0;
      if (i_resp) begin
        resp_n++;
        total++;
        if (i_rdata !== 32'h13) begin
          bad++; $display("FAIL fetch_rdata got=%h want=00000013", i_rdata);
        end
        i_read = 0;
      end
      tick();
    end
    total++;
    if (resp_n != 1) begin bad++; $display("FAIL fetch_resp_count got=%0d want=1", resp_n); end
    total++;
    if (d_seen || !addr_ok) begin
      bad++; $display("FAIL fetch_side_effects got d_resp_seen=%0d addr_ok=%0d want 0/1", d_seen, addr_ok);
    end
  endtask

  task automatic test_simultaneous();
    bit ok;
    logic [31:0] old_w;
    do_reset();
    fixed_lat = 2;
    old_w = rd_word(32'h1000);
    i_read = 1; i_address = 32'h64;
    d_write = 1; d_address = 32'h1000; d_wdata = 32'hDEADBEEF; d_byte_enable = 4'b0011;
    tick();
    total++;
    if ({mem_read, mem_write} !== 2'b01 || mem_byte_enable !== 4'b0011 ||
        mem_address !== 32'h1000 || mem_wdata !== 32'hDEADBEEF) begin
      bad++; $display("FAIL simul_d_first got rd=%b wr=%b be=%b addr=%h wd=%h want 0/1/0011/1000/deadbeef",
                      mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata);
    end
    ok = 0;
    for (int c = 0; c < 10; c++) begin
      if (d_resp) begin ok = 1; break; end
      tick();
    end
    total++;
    if (!ok) begin bad++; $display("FAIL simul_d_resp got=timeout want=d_resp"); end
    d_write = 0;
    tick();
    total++;
    if ({mem_read, mem_write} !== 2'b00) begin
      bad++; $display("FAIL simul_bubble got=%b want=00", {mem_read, mem_write});
    end
    tick();
    total++;
    if (mem_read !== 1'b1 || mem_address !== 32'h64 || mem_wdata !== 32'h0) begin
      bad++; $display("FAIL simul_fetch_next got rd=%b addr=%h wd=%h want 1/64/0", mem_read, mem_address, mem_wdata);
    end
    ok = 0;
    for (int c = 0; c < 10; c++) begin
      if (i_resp) begin ok = 1; break; end
      tick();
    end
    i_read = 0;
    total++;
    if (!ok) begin bad++; $display("FAIL simul_i_resp got=timeout want=i_resp"); end
    total++;
    if (rd_word(32'h1000) !== {old_w[31:16], 16'hBEEF}) begin
      bad++; $display("FAIL simul_write_data got=%h want=%h", rd_word(32'h1000), {old_w[31:16], 16'hBEEF});
    end
  endtask

  task automatic test_starvation();
    logic [31:0] exp_addr;
    do_reset();
    fixed_lat = 1;
    i_read = 1; i_address = 32'h100;
    d_read = 1; d_address = 32'h8000; d_byte_enable = 4'hF;
    for (int c = 0; c < 100 && mem_log.size() < 6; c++) begin
      tick();
      if (i_resp) begin
        total++;
        if (dut.starve_q !== 2'd0) begin
          bad++; $display("FAIL starve_clear got=%0d want=0", dut.starve_q);
        end
      end
    end
    i_read = 0; d_read = 0;
    total++;
    if (mem_log.size() < 6) begin
      bad++; $display("FAIL starve_timeout got=%0d grants want=6", mem_log.size());
    end else begin
      for (int g = 0; g < 6; g++) begin
        exp_addr = ((g % (LIM + 1)) == LIM) ? 32'h100 : 32'h8000;
        total++;
        if (mem_log[g].addr !== exp_addr || mem_log[g].wr !== 1'b0) begin
          bad++; $display("FAIL starve_order[%0d] got addr=%h wr=%0d want addr=%h wr=0",
                          g, mem_log[g].addr, mem_log[g].wr, exp_addr);
        end
      end
    end
  endtask

  task automatic test_request_drop();
    int resp_n = 0;
    bit addr_ok = 1;
    do_reset();
    fixed_lat = 4;
    d_read = 1; d_address = 32'h2000; d_byte_enable = 4'hF;
    tick();
    total++;
    if (mem_read !== 1'b1 || mem_address !== 32'h2000) begin
      bad++; $display("FAIL drop_grant got rd=%b addr=%h want 1/2000", mem_read, mem_address);
    end
    d_read = 0; d_address = 32'h3000;
    for (int c = 0; c < 10; c++) begin
      if (resp_n == 0 && (mem_read !== 1'b1 || mem_address !== 32'h2000)) addr_ok = 0;
      if (d_resp) resp_n++;
      tick();
    end
    total++;
    if (!addr_ok) begin bad++; $display("FAIL drop_addr_held got=changed want=2000 until resp"); end
    total++;
    if (resp_n != 1) begin bad++; $display("FAIL drop_resp_count got=%0d want=1", resp_n); end
    total++;
    if ({mem_read, mem_write} !== 2'b00) begin
      bad++; $display("FAIL drop_no_reserve got=%b want=00", {mem_read, mem_write});
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    mem_manual = 1;
    i_read = 1; i_address = 32'h200;
    d_read = 1; d_address = 32'h4000; d_byte_enable = 4'hF;
    tick();
    total++;
    if (mem_read !== 1'b1 || mem_address !== 32'h4000 || dut.starve_q !== 2'd1) begin
      bad++; $display("FAIL rstmid_pre got rd=%b addr=%h starve=%0d want 1/4000/1",
                      mem_read, mem_address, dut.starve_q);
    end
    rst = 1; i_read = 0; d_read = 0;
    tick();
    total++;
    if ({mem_read, mem_write} !== 2'b00) begin
      bad++; $display("FAIL rstmid_strobes got=%b want=00", {mem_read, mem_write});
    end
    rst = 0;
    tick();
    mem_resp = 1; mem_rdata = 32'hBADC0DE5;
    #1;
    total++;
    if ({i_resp, d_resp} !== 2'b00) begin
      bad++; $display("FAIL rstmid_late_resp got=%b want=00", {i_resp, d_resp});
    end
    total++;
    if (dut.state_q !== IDLE || dut.starve_q !== 2'd0) begin
      bad++; $display("FAIL rstmid_state got state=%0d starve=%0d want 0/0", dut.state_q, dut.starve_q);
    end
    tick();
    mem_resp = 0;
    total++;
    if (dut.state_q !== IDLE || {mem_read, mem_write} !== 2'b00) begin
      bad++; $display("FAIL rstmid_after got state=%0d strobes=%b want 0/00", dut.state_q, {mem_read, mem_write});
    end
    mem_manual = 0;
  endtask

  task automatic test_illegal_op();
    bit ok = 0;
    do_reset();
    fixed_lat = 2;
    d_read = 1; d_write = 1; d_address = 32'h5000; d_wdata = 32'h1234_5678; d_byte_enable = 4'b1100;
    tick();
    total++;
    if ({mem_read, mem_write} !== 2'b01) begin
      bad++; $display("FAIL illegal_as_write got rd/wr=%b want=01", {mem_read, mem_write});
    end
    for (int c = 0; c < 10; c++) begin
      if (d_resp) begin ok = 1; break; end
      tick();
    end
    d_read = 0; d_write = 0;
    total++;
    if (!ok || rd_word(32'h5000) !== {16'h1234, 16'h0F0F ^ 16'h5000}) begin
      bad++; $display("FAIL illegal_written got resp=%0d word=%h want 1/%h",
                      ok, rd_word(32'h5000), {16'h1234, 16'h0F0F ^ 16'h5000});
    end
  endtask

  // Transaction-level reference: at every idle slot, pick the winner from the
  // requests that were on the wires, then demand the memory side and resp routing follow.
  task automatic test_random();
    int serving = 0;
    bit p_i = 0, p_d = 0, p_dw = 0, resp_prev = 0;
    logic [31:0] p_ia = 0, p_da = 0, p_wd = 0;
    logic [3:0] p_be = 0;
    logic [1:0] scnt = 0;
    bit e_rd = 0, e_wr = 0;
    logic [3:0] e_be = 0;
    logic [31:0] e_addr = 0, e_wd = 0;
    bit i_busy = 0, d_busy = 0;
    int n_i = 0, n_d = 0, errs = 0;
    do_reset();
    tick();
    for (int c = 0; c < 600; c++) begin
      if (serving == 0) begin
        if (p_d && !(p_i && scnt == 2'(LIM))) begin
          serving = 2; n_d++;
          e_rd = !p_dw; e_wr = p_dw; e_be = p_be; e_addr = p_da; e_wd = p_wd;
          if (p_i && scnt < 2'(LIM)) scnt = scnt + 2'd1;
        end else if (p_i) begin
          serving = 1; n_i++;
          e_rd = 1; e_wr = 0; e_be = 4'hF; e_addr = p_ia; e_wd = 0;
          scnt = 0;
        end
      end else if (resp_prev) begin
        serving = 0;
      end
      total++;
      if (serving == 0) begin
        if ({mem_read, mem_write, i_resp, d_resp} !== 4'b0000) begin
          bad++; errs++;
          if (errs < 10) $display("FAIL rand_idle cyc=%0d got rd/wr/ir/dr=%b want=0000",
                                  c, {mem_read, mem_write, i_resp, d_resp});
        end
      end else if (mem_read !== e_rd || mem_write !== e_wr || mem_byte_enable !== e_be ||
                   mem_address !== e_addr || mem_wdata !== e_wd ||
                   i_resp !== (mem_resp && serving == 1) || d_resp !== (mem_resp && serving == 2) ||
                   (serving == 1 ? i_rdata : d_rdata) !== mem_rdata) begin
        bad++; errs++;
        if (errs < 10) $display("FAIL rand_serve cyc=%0d got rd=%b wr=%b be=%h a=%h wd=%h ir=%b dr=%b want rd=%b wr=%b be=%h a=%h wd=%h side=%0d",
                                c, mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata, i_resp, d_resp,
                                e_rd, e_wr, e_be, e_addr, e_wd, serving);
      end
      total++;
      if (dut.starve_q !== scnt) begin
        bad++; errs++;
        if (errs < 10) $display("FAIL rand_starve cyc=%0d got=%0d want=%0d", c, dut.starve_q, scnt);
      end
      resp_prev = (serving != 0) && mem_resp;
      if (serving == 1 && mem_resp) i_busy = 0;
      if (serving == 2 && mem_resp) d_busy = 0;
      if (!i_busy && $urandom_range(0, 2) == 0) begin
        i_busy = 1;
        i_address = 32'h0001_0000 + 4 * $urandom_range(0, 255);
      end
      i_read = i_busy;
      if (!d_busy && $urandom_range(0, 1) == 0) begin
        d_busy = 1;
        d_write = $urandom_range(0, 1) == 1;
        d_read = !d_write;
        d_address = 32'h0002_0000 + 4 * $urandom_range(0, 255);
        d_wdata = $urandom;
        d_byte_enable = 4'($urandom);
      end else if (!d_busy) begin
        d_read = 0; d_write = 0;
      end
      p_i = i_read; p_ia = i_address;
      p_d = d_read | d_write; p_dw = d_write; p_da = d_address; p_wd = d_wdata; p_be = d_byte_enable;
      tick();
    end
    i_read = 0; d_read = 0; d_write = 0;
    total++;
    if (n_i == 0 || n_d == 0) begin
      bad++; $display("FAIL rand_coverage got i_grants=%0d d_grants=%0d want both >0", n_i, n_d);
    end
  endtask

  task automatic test_invariants();
    total++;
    if (both_resp_cnt != 0) begin bad++; $display("FAIL inv_both_resp got=%0d want=0", both_resp_cnt); end
    total++;
    if (rw_cnt != 0) begin bad++; $display("FAIL inv_read_write got=%0d want=0", rw_cnt); end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_starvation();
    test_request_drop();
    test_reset_mid();
    test_illegal_op();
    test_random();
    do_reset();
    test_invariants();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one word-wide physical memory port between an instruction-fetch requester (read-only) and a data requester (read/write).
- Sits between the CPU's fetch/load-store logic and memory. Presents the same mem_read/mem_write/mem_byte_enable/mem_address/mem_wdata/mem_rdata/mem_resp protocol on every side.
- Data has priority. A starvation counter guarantees fetch progress.

Parameters:
- STARVE_LIMIT, 4: max consecutive data grants while a fetch is waiting. 0 gives fetch strict priority.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_read  in  1  fetch read request, held until i_resp
- i_address  in  32  fetch address
- i_rdata  out  32  fetch read data
- i_resp  out  1  fetch transaction complete
- d_read  in  1  data read request, held until d_resp
- d_write  in  1  data write request, held until d_resp
- d_byte_enable  in  4  data write byte enables
- d_address  in  32  data address
- d_wdata  in  32  data write data
- d_rdata  out  32  data read data
- d_resp  out  1  data transaction complete
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_byte_enable  out  4  memory byte enables
- mem_address  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data
- mem_resp  in  1  memory complete, one-cycle pulse

Behaviour:
- States: IDLE, SERVE_I, SERVE_D.
- Reset values: state=IDLE, starve_cnt=0, all latched request registers 0. Therefore mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata, i_resp and d_resp are all 0.
- Grant decision, made in IDLE only:
  - If d_read|d_write is asserted and NOT (i_read && starve_cnt==STARVE_LIMIT), grant D.
  - Otherwise, if i_read is asserted, grant I.
  - Otherwise stay in IDLE.
- On a grant, at the clock edge:
  - Latch op, address, byte_enable and wdata into internal registers.
  - State becomes SERVE_I or SERVE_D.
  - A fetch grant latches mem_byte_enable=4'hF, wdata=0, op=read.
- Latency: request seen in IDLE at cycle N, so mem_* is driven from the latched registers starting at cycle N+1.
- mem_* outputs are driven only from registers and are forced to 0 in IDLE. They never change mid-transaction, even if the requester drops or alters its request.
- Completion:
  - In SERVE_I, i_resp = mem_resp.
  - In SERVE_D, d_resp = mem_resp.
  - Both are combinational, same cycle as mem_resp.
  - i_rdata = d_rdata = mem_rdata unconditionally; valid only with the matching resp.
- On mem_resp in SERVE_x, next state is IDLE.
- There is a mandatory one-cycle IDLE bubble between transactions. This lets the requester deassert after its resp before re-arbitration, so a stale request is never re-served.
- starve_cnt:
  - On a D grant while i_read=1: starve_cnt+1, saturating at STARVE_LIMIT.
  - On an I grant: cleared to 0.
  - Otherwise: unchanged.
  - Width is $clog2(STARVE_LIMIT+1), minimum 1.
- d_read && d_write together is illegal. The arbiter latches a write (mem_write=1, mem_read=0), and a simulation assertion fires.
- mem_resp while in IDLE is ignored: no resp is routed and there is no state change.
- Requester withdrawing mid-transaction: the transaction still completes to memory, and the resp pulse is still emitted.
- rst mid-transaction: next cycle IDLE, mem_* deasserted, starve_cnt=0. A late mem_resp is ignored per the IDLE rule.
- Never drive mem_read and mem_write simultaneously. Never assert i_resp and d_resp in the same cycle.

Decomposition:
- Shared package rv32i_types (existing): rv32i_word.
- New arb_state_t enum (IDLE, SERVE_I, SERVE_D) goes in a shared package arbiter_types, for reuse by the cache-line arbiter.
- No sub-module: FSM, starvation counter and request latch fit in a single module.

Test Plan:
- Single fetch: i_read=1, i_address=32'h60, memory resp after 3 cycles with rdata=32'h00000013.
  - mem_read=1 and mem_address=32'h60 from the cycle after the request.
  - i_resp=1 for exactly one cycle with i_rdata=32'h13.
  - d_resp stays 0.
- Simultaneous requests: i_read=1 (addr 32'h64) and d_write=1 (addr 32'h1000, wdata 32'hDEADBEEF, be 4'b0011) in the same cycle.
  - D served first: mem_write=1, mem_byte_enable=4'b0011.
  - After d_resp, one IDLE cycle, then the fetch of 32'h64.
- Starvation with STARVE_LIMIT=2: i_read held and d_read re-asserted continuously.
  - Grant order is D, D, I, D, D, I.
  - starve_cnt returns to 0 after each I grant.
- Request drop: d_read for 32'h2000 granted, then d_read deasserted and d_address changed to 32'h3000 mid-transaction.
  - mem_address stays 32'h2000 until mem_resp.
  - d_resp still pulses.
- Reset mid-transaction: rst during SERVE_D, then mem_resp arrives 2 cycles later.
  - mem_read/mem_write are 0 the cycle after rst.
  - No d_resp or i_resp is produced.
  - State is IDLE, starve_cnt=0.
- Illegal op: d_read=d_write=1.
  - mem_write=1, mem_read=0.
  - Assertion fires.
